// File: rtl/motor_pwm_bridge.sv
// Drives 4 H-bridge pin pairs from a motor select word. Adds shared-duty PWM and a per-motor
// dead-time interlock on reversal. Define SOFT_START_EN for a per-motor soft-start duty ramp.
module motor_pwm_bridge #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned DEAD_CYCLES = 64,
  parameter int unsigned RAMP_STEP   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          sel,
  input  logic [PWM_BITS-1:0] duty,
  output logic [7:0]          hb_out,
  output logic                pwm_tick,
  output logic [3:0]          dead_busy
);

  localparam int unsigned NumMotors = 4;
  localparam logic [15:0] DeadInit = 16'(DEAD_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] CntMax = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] CntOne = PWM_BITS'(1);

  if (DEAD_CYCLES < 1 || DEAD_CYCLES > 65535 || RAMP_STEP < 1) begin : g_param_check
    $error("motor_pwm_bridge: illegal parameter value");
  end

  typedef enum logic [1:0] {StOff, StRun, StDead} motor_st_e;

  logic [7:0]           sel_q;
  logic [PWM_BITS-1:0]  duty_q, duty_d;
  logic [PWM_BITS-1:0]  cnt_q;
  logic                 cnt_max;
  logic                 tick_q;
  logic [7:0]           hb_q, hb_d;
  motor_st_e            state_q [NumMotors];
  motor_st_e            state_d [NumMotors];
  logic [NumMotors-1:0] dir_q, dir_d;  // 1 = reverse
  logic [15:0]          dead_cnt_q [NumMotors];
  logic [15:0]          dead_cnt_d [NumMotors];
  logic [NumMotors-1:0] fwd, rev;
  logic [PWM_BITS-1:0]  cmp_duty [NumMotors];

`ifdef SOFT_START_EN
  localparam int unsigned RampW = PWM_BITS + 1;
  localparam logic [PWM_BITS:0] RampStep = RampW'(RAMP_STEP);
  logic [PWM_BITS-1:0]  eff_q [NumMotors];
  logic [PWM_BITS-1:0]  eff_d [NumMotors];
  logic [PWM_BITS:0]    ramp_sum [NumMotors];
`endif

  assign cnt_max  = (cnt_q == CntMax);
  assign hb_out   = hb_q;
  assign pwm_tick = tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      duty_q <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      hb_q   <= '0;
      dir_q  <= '0;
      for (int m = 0; m < NumMotors; m++) begin
        state_q[m]    <= StOff;
        dead_cnt_q[m] <= '0;
`ifdef SOFT_START_EN
        eff_q[m]      <= '0;
`endif
      end
    end else begin
      sel_q  <= sel;
      duty_q <= duty_d;
      cnt_q  <= cnt_q + CntOne;
      tick_q <= cnt_max;  // high exactly while cnt_q == 0
      hb_q   <= hb_d;
      dir_q  <= dir_d;
      for (int m = 0; m < NumMotors; m++) begin
        state_q[m]    <= state_d[m];
        dead_cnt_q[m] <= dead_cnt_d[m];
`ifdef SOFT_START_EN
        eff_q[m]      <= eff_d[m];
`endif
      end
    end
  end

  always_comb begin
    duty_d    = cnt_max ? duty : duty_q;
    hb_d      = '0;
    dir_d     = dir_q;
    dead_busy = '0;
    for (int m = 0; m < NumMotors; m++) begin
      fwd[m]        = (sel_q[2*m +: 2] == 2'b01);
      rev[m]        = (sel_q[2*m +: 2] == 2'b10);
      state_d[m]    = state_q[m];
      dead_cnt_d[m] = dead_cnt_q[m];
      dead_busy[m]  = (state_q[m] == StDead);

      unique case (state_q[m])
        StOff: begin
          if (fwd[m] || rev[m]) begin
            state_d[m] = StRun;
            dir_d[m]   = rev[m];
          end
        end
        StRun: begin
          if (!fwd[m] && !rev[m]) begin
            state_d[m] = StOff;
          end else if (rev[m] != dir_q[m]) begin
            state_d[m]    = StDead;
            dead_cnt_d[m] = DeadInit;
          end
        end
        StDead: begin
          // Direction flips inside DEAD keep counting; only STOP abandons the count.
          if (!fwd[m] && !rev[m]) begin
            state_d[m] = StOff;
          end else if (dead_cnt_q[m] == '0) begin
            state_d[m] = StRun;
            dir_d[m]   = rev[m];
          end else begin
            dead_cnt_d[m] = dead_cnt_q[m] - 16'd1;
          end
        end
        default: state_d[m] = StOff;
      endcase

`ifdef SOFT_START_EN
      // Ramp steps on the period boundary, clipped to the duty taking effect there.
      ramp_sum[m] = {1'b0, eff_q[m]} + RampStep;
      eff_d[m]    = eff_q[m];
      if (state_d[m] == StRun && state_q[m] != StRun) begin
        eff_d[m] = '0;
      end else if (cnt_max) begin
        eff_d[m] = (ramp_sum[m] > {1'b0, duty_d}) ? duty_d : ramp_sum[m][PWM_BITS-1:0];
      end
      cmp_duty[m] = eff_q[m];
`else
      cmp_duty[m] = duty_q;
`endif

      hb_d[2*m]   = (state_q[m] == StRun) && (cnt_q < cmp_duty[m]) && !dir_q[m];
      hb_d[2*m+1] = (state_q[m] == StRun) && (cnt_q < cmp_duty[m]) && dir_q[m];
    end
  end

endmodule

// File: tb/tb_motor_pwm_bridge.sv
// Directed bench for motor_pwm_bridge: expected per-pin high counts queued per stimulus step
// and compared per PWM period; a monitor tracks pair legality and reversal gaps throughout.
`timescale 1ns/1ps
module tb_motor_pwm_bridge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sel;
  logic [7:0] duty;
  logic [7:0] hb_out;
  logic       pwm_tick;
  logic [3:0] dead_busy;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];
  int          hcnt [8];
  int          viol = 0;
  logic [1:0]  last_nz [4];
  int          zrun [4];

`ifdef SOFT_START_EN
  localparam int Settle   = 17;
  localparam int NextDuty = 48;
`else
  localparam int Settle   = 1;
  localparam int NextDuty = 128;
`endif

  always #5 clk = ~clk;

  motor_pwm_bridge dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (sel),
    .duty     (duty),
    .hb_out   (hb_out),
    .pwm_tick (pwm_tick),
    .dead_busy(dead_busy)
  );

  // Interlock monitor: no pair 11, no 01<->10 without 64 consecutive 00 samples between.
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (!rst_n) begin
        last_nz[m] = 2'b00;
        zrun[m]    = 0;
      end else if (hb_out[2*m +: 2] == 2'b11) begin
        viol++;
      end else if (hb_out[2*m +: 2] == 2'b00) begin
        zrun[m]++;
      end else begin
        if (last_nz[m] != 2'b00 && hb_out[2*m +: 2] != last_nz[m] && zrun[m] < 64) viol++;
        last_nz[m] = hb_out[2*m +: 2];
        zrun[m]    = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       tag;
    logic [31:0] v;
    chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    tag = tag_q.pop_front();
    v   = exp_q.pop_front();
    chk(tag, obs, v);
  endtask

  function automatic int exp_high(input logic [7:0] s, input int d, input int b);
    logic [1:0] p;
    p = s[(b/2)*2 +: 2];
    if (p == 2'b01 && b % 2 == 0) return d;
    if (p == 2'b10 && b % 2 == 1) return d;
    return 0;
  endfunction

  task automatic exp_pwm(input logic [7:0] s, input int d);
    for (int b = 0; b < 8; b++)
      sb_push($sformatf("high_b%0d_sel%02h_d%0d", b, s, d), 32'(exp_high(s, d, b)));
  endtask

  task automatic chk_pwm();
    for (int b = 0; b < 8; b++) sb_check(32'(hcnt[b]));
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pwm_tick !== 1'b1 && n < 300);
    chk("tick_seen", 32'(pwm_tick), 1);
  endtask

  task automatic skip_period();
    repeat (Settle) begin
      wait_tick();
      repeat (255) @(negedge clk);
    end
  endtask

  // Counts high samples per pin across one PWM period starting at a tick.
  task automatic measure(input int change_at, input logic [7:0] new_duty);
    for (int b = 0; b < 8; b++) hcnt[b] = 0;
    wait_tick();
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      if (i == change_at) duty = new_duty;
      for (int b = 0; b < 8; b++) if (hb_out[b] === 1'b1) hcnt[b]++;
    end
  endtask

  initial begin
    int         n;
    int         dcount;
    int         hbbad;
    int         pcount;
    logic [3:0] prev_busy;

    // Reset state
    rst_n = 1'b0;
    sel   = 8'h55;
    duty  = 8'd200;
    repeat (3) @(negedge clk);
    chk("rst_hb", 32'(hb_out), 0);
    chk("rst_tick", 32'(pwm_tick), 0);
    chk("rst_busy", 32'(dead_busy), 0);
    duty = 8'd64;
    #2 rst_n = 1'b1;

    // PWM duty sweep
    skip_period();
    exp_pwm(8'h55, 64);
    measure(-1, 8'd0);
    chk_pwm();
    wait_tick();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pwm_tick !== 1'b1 && n < 300);
    chk("tick_period", 32'(n), 256);

    duty = 8'd0;
    skip_period();
    exp_pwm(8'h55, 0);
    measure(-1, 8'd0);
    chk_pwm();

    duty = 8'd255;
    skip_period();
    exp_pwm(8'h55, 255);
    measure(-1, 8'd0);
    chk_pwm();

    // Reversal on all motors
    sb_push("dead_len", 64);
    sel       = 8'hAA;
    dcount    = 0;
    hbbad     = 0;
    prev_busy = 4'h0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dead_busy === 4'hF) dcount++;
      if (prev_busy != 4'h0 && hb_out !== 8'h00) hbbad++;
      prev_busy = dead_busy;
      if (dcount > 0 && dead_busy === 4'h0) break;
    end
    sb_check(32'(dcount));
    chk("dead_hb_quiet", 32'(hbbad), 0);
    chk("dead_done", 32'(dead_busy), 0);
    skip_period();
    exp_pwm(8'hAA, 255);
    measure(-1, 8'd0);
    chk_pwm();

    // Abort dead on motor 0 with STOP, then restart without dead time
    sel = 8'hA9;
    repeat (12) @(negedge clk);
    chk("abort_busy_pre", 32'(dead_busy), 32'h1);
    sel = 8'hA8;
    repeat (2) @(negedge clk);
    chk("abort_busy_drop", 32'(dead_busy[0]), 0);
    @(negedge clk);
    chk("abort_off_hb", 32'(hb_out[1:0]), 0);
    repeat (100) @(negedge clk);
    sel    = 8'hA9;
    pcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (dead_busy[0] !== 1'b0) pcount++;
    end
    chk("restart_no_dead", 32'(pcount), 0);
    skip_period();
    exp_pwm(8'hA9, 255);
    measure(-1, 8'd0);
    chk_pwm();

    // Duty change mid-period holds until the next period start
    duty = 8'd32;
    skip_period();
    exp_pwm(8'hA9, 32);
    measure(100, 8'd128);
    chk_pwm();
    exp_pwm(8'hA9, NextDuty);
    measure(-1, 8'd0);
    chk_pwm();

    // Illegal pair 11 on motor 1 behaves as STOP
    sel = 8'h5D;
    skip_period();
    exp_pwm(8'h5D, 128);
    measure(-1, 8'd0);
    chk_pwm();

    // Asynchronous reset in the middle of DEAD
    sel = 8'hAA;
    repeat (20) @(negedge clk);
    chk("dead_mix", 32'(dead_busy), 32'hD);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hb", 32'(hb_out), 0);
    chk("async_rst_busy", 32'(dead_busy), 0);
    chk("async_rst_tick", 32'(pwm_tick), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    skip_period();
    exp_pwm(8'hAA, 128);
    measure(-1, 8'd0);
    chk_pwm();

`ifdef SOFT_START_EN
    // Soft-start ramp from OFF with entry aligned to a period start
    sel  = 8'h00;
    duty = 8'd100;
    skip_period();
    wait_tick();
    repeat (254) @(negedge clk);
    sel = 8'h55;
    foreach (hcnt[i]) hcnt[i] = 0;
    for (int p = 0; p < 9; p++) begin
      exp_pwm(8'h55, (p < 7) ? p * 16 : 100);
      measure(-1, 8'd0);
      chk_pwm();
    end
`endif

    chk("interlock", 32'(viol), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
